// File: rtl/rob.sv
// -----------------------------------------------------------------------------
// rob - circular reorder buffer and the producer side of operand forwarding.
//
// Allocates one entry per issued instruction in program order. It captures
// results from the ALU, MEM and MUL writeback ports, serves two combinational
// operand read ports, and retires completed entries in order.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   flush               synchronous squash of every entry and pointer
//   alloc_valid/_rd     allocation request and destination register
//   alloc_ready/_rob_id not-full indication and id granted (current tail)
//   {alu,mem,mul}_wb_*  writeback strobe, target entry and result
//   rs{1,2}_rob_entry   read addresses
//   rob_s{1,2}_data     stored result (0 when the entry is not busy)
//   rob_s{1,2}_valid    entry busy and result ready
//   commit_*            head retirement: valid, rd, data, id
//   count, empty        occupancy
// -----------------------------------------------------------------------------
module rob #(
  parameter int WORD_SIZE       = 32,
  parameter int ROB_ENTRY_WIDTH = 3,
  parameter int REG_ADDR_WIDTH  = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,

  input  logic                       alloc_valid,
  input  logic [REG_ADDR_WIDTH-1:0]  alloc_rd,
  output logic                       alloc_ready,
  output logic [ROB_ENTRY_WIDTH-1:0] alloc_rob_id,

  input  logic                       alu_wb_valid,
  input  logic [ROB_ENTRY_WIDTH-1:0] alu_wb_rob_id,
  input  logic [WORD_SIZE-1:0]       alu_wb_data,
  input  logic                       mem_wb_valid,
  input  logic [ROB_ENTRY_WIDTH-1:0] mem_wb_rob_id,
  input  logic [WORD_SIZE-1:0]       mem_wb_data,
  input  logic                       mul_wb_valid,
  input  logic [ROB_ENTRY_WIDTH-1:0] mul_wb_rob_id,
  input  logic [WORD_SIZE-1:0]       mul_wb_data,

  input  logic [ROB_ENTRY_WIDTH-1:0] rs1_rob_entry,
  input  logic [ROB_ENTRY_WIDTH-1:0] rs2_rob_entry,
  output logic [WORD_SIZE-1:0]       rob_s1_data,
  output logic [WORD_SIZE-1:0]       rob_s2_data,
  output logic                       rob_s1_valid,
  output logic                       rob_s2_valid,

  output logic                       commit_valid,
  output logic [REG_ADDR_WIDTH-1:0]  commit_rd,
  output logic [WORD_SIZE-1:0]       commit_data,
  output logic [ROB_ENTRY_WIDTH-1:0] commit_rob_id,

  output logic [ROB_ENTRY_WIDTH:0]   count,
  output logic                       empty
);

  localparam int unsigned DEPTH = 1 << ROB_ENTRY_WIDTH;
  localparam logic [ROB_ENTRY_WIDTH:0] FULL_CNT = (ROB_ENTRY_WIDTH+1)'(DEPTH);

  logic [DEPTH-1:0]          busy_q,  busy_d;
  logic [DEPTH-1:0]          ready_q, ready_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q   [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] rd_d   [DEPTH];
  logic [WORD_SIZE-1:0]      data_q [DEPTH];
  logic [WORD_SIZE-1:0]      data_d [DEPTH];

  logic [ROB_ENTRY_WIDTH-1:0] head_q,  head_d;
  logic [ROB_ENTRY_WIDTH-1:0] tail_q,  tail_d;
  logic [ROB_ENTRY_WIDTH:0]   count_q, count_d;

  logic alloc_fire;

  // Full/empty come from count only; head == tail is ambiguous.
  assign alloc_ready   = (count_q != FULL_CNT);
  assign alloc_rob_id  = tail_q;
  assign alloc_fire    = alloc_valid && alloc_ready;
  assign count         = count_q;
  assign empty         = (count_q == '0);

  assign commit_valid  = busy_q[head_q] && ready_q[head_q] && !flush;
  assign commit_rd     = rd_q[head_q];
  assign commit_data   = data_q[head_q];
  assign commit_rob_id = head_q;

  // Read ports see registered state only; same-cycle writebacks are
  // bypassed by the forward unit.
  assign rob_s1_valid  = busy_q[rs1_rob_entry] && ready_q[rs1_rob_entry];
  assign rob_s2_valid  = busy_q[rs2_rob_entry] && ready_q[rs2_rob_entry];
  assign rob_s1_data   = busy_q[rs1_rob_entry] ? data_q[rs1_rob_entry] : '0;
  assign rob_s2_data   = busy_q[rs2_rob_entry] ? data_q[rs2_rob_entry] : '0;

  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    rd_d    = rd_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    // Lowest priority first so ALU > MEM > MUL on a shared target.
    if (mul_wb_valid && busy_q[mul_wb_rob_id]) begin
      ready_d[mul_wb_rob_id] = 1'b1;
      data_d[mul_wb_rob_id]  = mul_wb_data;
    end
    if (mem_wb_valid && busy_q[mem_wb_rob_id]) begin
      ready_d[mem_wb_rob_id] = 1'b1;
      data_d[mem_wb_rob_id]  = mem_wb_data;
    end
    if (alu_wb_valid && busy_q[alu_wb_rob_id]) begin
      ready_d[alu_wb_rob_id] = 1'b1;
      data_d[alu_wb_rob_id]  = alu_wb_data;
    end

    if (commit_valid) begin
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end

    // Alloc never targets the committing head: that would require a full
    // buffer, and a full buffer refuses the alloc.
    if (alloc_fire) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      rd_d[tail_q]    = alloc_rd;
      tail_d          = tail_q + 1'b1;
    end

    case ({alloc_fire, commit_valid})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (flush) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      ready_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      ready_q <= ready_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_rob.sv
module tb_rob;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic        alloc_ready;
  logic [2:0]  alloc_rob_id;
  logic        alu_wb_valid, mem_wb_valid, mul_wb_valid;
  logic [2:0]  alu_wb_rob_id, mem_wb_rob_id, mul_wb_rob_id;
  logic [31:0] alu_wb_data, mem_wb_data, mul_wb_data;
  logic [2:0]  rs1_rob_entry, rs2_rob_entry;
  logic [31:0] rob_s1_data, rob_s2_data;
  logic        rob_s1_valid, rob_s2_valid;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  logic [2:0]  commit_rob_id;
  logic [3:0]  count;
  logic        empty;

  int tests  = 0;
  int errors = 0;

  rob #(.WORD_SIZE(32), .ROB_ENTRY_WIDTH(3), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_rob_id(alloc_rob_id),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rob_id(alu_wb_rob_id), .alu_wb_data(alu_wb_data),
    .mem_wb_valid(mem_wb_valid), .mem_wb_rob_id(mem_wb_rob_id), .mem_wb_data(mem_wb_data),
    .mul_wb_valid(mul_wb_valid), .mul_wb_rob_id(mul_wb_rob_id), .mul_wb_data(mul_wb_data),
    .rs1_rob_entry(rs1_rob_entry), .rs2_rob_entry(rs2_rob_entry),
    .rob_s1_data(rob_s1_data), .rob_s2_data(rob_s2_data),
    .rob_s1_valid(rob_s1_valid), .rob_s2_valid(rob_s2_valid),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_data(commit_data), .commit_rob_id(commit_rob_id),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    flush = 0; alloc_valid = 0; alloc_rd = '0;
    alu_wb_valid = 0; alu_wb_rob_id = '0; alu_wb_data = '0;
    mem_wb_valid = 0; mem_wb_rob_id = '0; mem_wb_data = '0;
    mul_wb_valid = 0; mul_wb_rob_id = '0; mul_wb_data = '0;
    rs1_rob_entry = '0; rs2_rob_entry = '0;
  endtask

  // Advance one edge; inputs for the new cycle are driven 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".alloc_ready"},  64'(alloc_ready), 64'd1);
    check({tag, ".alloc_rob_id"}, 64'(alloc_rob_id), 64'd0);
    check({tag, ".empty"},        64'(empty), 64'd1);
    check({tag, ".count"},        64'(count), 64'd0);
    check({tag, ".commit_valid"}, 64'(commit_valid), 64'd0);
    check({tag, ".commit_rd"},    64'(commit_rd), 64'd0);
    check({tag, ".commit_data"},  64'(commit_data), 64'd0);
    check({tag, ".commit_id"},    64'(commit_rob_id), 64'd0);
    check({tag, ".s1_valid"},     64'(rob_s1_valid), 64'd0);
    check({tag, ".s1_data"},      64'(rob_s1_data), 64'd0);
    check({tag, ".s2_valid"},     64'(rob_s2_valid), 64'd0);
    check({tag, ".s2_data"},      64'(rob_s2_data), 64'd0);
  endtask

  initial begin
    idle();
    #2;
    check_reset_outputs("rst");
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1; idle();

    // ---- single alloc / writeback / commit ----
    alloc_valid = 1; alloc_rd = 5'd5; #1;
    check("s1.alloc_id", 64'(alloc_rob_id), 64'd0);
    check("s1.alloc_ready", 64'(alloc_ready), 64'd1);
    cyc();
    rs1_rob_entry = 3'd0;
    alu_wb_valid = 1; alu_wb_rob_id = 3'd0; alu_wb_data = 32'h1234; #1;
    check("s1.busy_not_ready", 64'(rob_s1_valid), 64'd0);
    check("s1.count1", 64'(count), 64'd1);
    check("s1.no_commit_yet", 64'(commit_valid), 64'd0);
    cyc();
    rs1_rob_entry = 3'd0; #1;
    check("s1.commit_valid", 64'(commit_valid), 64'd1);
    check("s1.commit_rd", 64'(commit_rd), 64'd5);
    check("s1.commit_data", 64'(commit_data), 64'h1234);
    check("s1.s1_valid", 64'(rob_s1_valid), 64'd1);
    check("s1.s1_data", 64'(rob_s1_data), 64'h1234);
    cyc(); #1;
    check("s1.empty", 64'(empty), 64'd1);
    check("s1.commit_gone", 64'(commit_valid), 64'd0);
    check("s1.alloc_id_next", 64'(alloc_rob_id), 64'd1);

    // ---- out-of-order writeback, in-order commit ----
    flush = 1; cyc();
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1; alloc_rd = 5'(i + 1); #1;
      check("s2.alloc_id", 64'(alloc_rob_id), 64'(i));
      cyc();
    end
    mul_wb_valid = 1; mul_wb_rob_id = 3'd2; mul_wb_data = 32'd7; rs1_rob_entry = 3'd2; #1;
    check("s2.id2_not_ready", 64'(rob_s1_valid), 64'd0);
    cyc();
    mem_wb_valid = 1; mem_wb_rob_id = 3'd0; mem_wb_data = 32'd9; rs1_rob_entry = 3'd2; #1;
    check("s2.id2_ready_early", 64'(rob_s1_valid), 64'd1);
    check("s2.id2_data", 64'(rob_s1_data), 64'd7);
    check("s2.head_blocked", 64'(commit_valid), 64'd0);
    cyc();
    alu_wb_valid = 1; alu_wb_rob_id = 3'd1; alu_wb_data = 32'd3; #1;
    check("s2.c0_valid", 64'(commit_valid), 64'd1);
    check("s2.c0_id", 64'(commit_rob_id), 64'd0);
    check("s2.c0_data", 64'(commit_data), 64'd9);
    check("s2.c0_rd", 64'(commit_rd), 64'd1);
    cyc(); #1;
    check("s2.c1_valid", 64'(commit_valid), 64'd1);
    check("s2.c1_id", 64'(commit_rob_id), 64'd1);
    check("s2.c1_data", 64'(commit_data), 64'd3);
    check("s2.c1_rd", 64'(commit_rd), 64'd2);
    cyc(); #1;
    check("s2.c2_valid", 64'(commit_valid), 64'd1);
    check("s2.c2_id", 64'(commit_rob_id), 64'd2);
    check("s2.c2_data", 64'(commit_data), 64'd7);
    check("s2.c2_rd", 64'(commit_rd), 64'd3);
    cyc(); #1;
    check("s2.empty", 64'(empty), 64'd1);

    // ---- fill to full ----
    flush = 1; cyc();
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1; alloc_rd = 5'(i + 10); #1;
      check("s3.fill_id", 64'(alloc_rob_id), 64'(i));
      cyc();
    end
    alloc_valid = 1; alloc_rd = 5'd30; #1;
    check("s3.full_ready", 64'(alloc_ready), 64'd0);
    check("s3.full_count", 64'(count), 64'd8);
    check("s3.full_empty", 64'(empty), 64'd0);
    cyc();
    alu_wb_valid = 1; alu_wb_rob_id = 3'd0; alu_wb_data = 32'h55; #1;
    check("s3.blocked_count", 64'(count), 64'd8);
    check("s3.tail_wrapped", 64'(alloc_rob_id), 64'd0);
    cyc();
    alloc_valid = 1; alloc_rd = 5'd31; #1;
    check("s3.commit_when_full", 64'(commit_valid), 64'd1);
    check("s3.commit_rd", 64'(commit_rd), 64'd10);
    check("s3.no_same_cycle_slot", 64'(alloc_ready), 64'd0);
    cyc(); #1;
    check("s3.freed_count", 64'(count), 64'd7);
    check("s3.freed_ready", 64'(alloc_ready), 64'd1);
    check("s3.freed_id", 64'(alloc_rob_id), 64'd0);
    alloc_valid = 1; alloc_rd = 5'd31;
    cyc();
    rs1_rob_entry = 3'd0; #1;
    check("s3.refill_count", 64'(count), 64'd8);
    check("s3.refill_not_ready", 64'(rob_s1_valid), 64'd0);
    check("s3.head_moved", 64'(commit_rob_id), 64'd1);

    // ---- pipelined rounds across wrap-around ----
    flush = 1; cyc();
    for (int k = 0; k < 22; k++) begin
      int acnt, ccnt;
      if (k < 20) begin
        alloc_valid = 1; alloc_rd = 5'((k % 31) + 1);
      end
      if (k >= 1 && k <= 20) begin
        case (k % 3)
          0: begin alu_wb_valid = 1; alu_wb_rob_id = 3'((k-1) % 8); alu_wb_data = 32'(32'h1000 + k - 1); end
          1: begin mem_wb_valid = 1; mem_wb_rob_id = 3'((k-1) % 8); mem_wb_data = 32'(32'h1000 + k - 1); end
          default: begin mul_wb_valid = 1; mul_wb_rob_id = 3'((k-1) % 8); mul_wb_data = 32'(32'h1000 + k - 1); end
        endcase
      end
      #1;
      acnt = (k < 20) ? k : 20;
      ccnt = (k < 2) ? 0 : ((k - 2 < 20) ? k - 2 : 20);
      check("s4.count", 64'(count), 64'(acnt - ccnt));
      if (k < 20) check("s4.alloc_id", 64'(alloc_rob_id), 64'(k % 8));
      if (k >= 2) begin
        check("s4.commit_valid", 64'(commit_valid), 64'd1);
        check("s4.commit_id", 64'(commit_rob_id), 64'((k-2) % 8));
        check("s4.commit_data", 64'(commit_data), 64'(32'h1000 + k - 2));
        check("s4.commit_rd", 64'(commit_rd), 64'(((k-2) % 31) + 1));
      end else begin
        check("s4.commit_idle", 64'(commit_valid), 64'd0);
      end
      cyc();
    end
    #1;
    check("s4.drained", 64'(empty), 64'd1);

    // ---- flush with live entries ----
    flush = 1; cyc();
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1; alloc_rd = 5'(i + 1); cyc();
    end
    alu_wb_valid = 1; alu_wb_rob_id = 3'd0; alu_wb_data = 32'hA0;
    mem_wb_valid = 1; mem_wb_rob_id = 3'd1; mem_wb_data = 32'hA1;
    cyc();
    rs1_rob_entry = 3'd0; rs2_rob_entry = 3'd1; #1;
    check("s5.pre_commit", 64'(commit_valid), 64'd1);
    check("s5.pre_count", 64'(count), 64'd4);
    flush = 1; alloc_valid = 1; alloc_rd = 5'd9;
    mul_wb_valid = 1; mul_wb_rob_id = 3'd2; mul_wb_data = 32'hDEAD; #1;
    check("s5.flush_blocks_commit", 64'(commit_valid), 64'd0);
    cyc();
    rs1_rob_entry = 3'd0; rs2_rob_entry = 3'd2; #1;
    check("s5.count0", 64'(count), 64'd0);
    check("s5.alloc_id0", 64'(alloc_rob_id), 64'd0);
    check("s5.s1_invalid", 64'(rob_s1_valid), 64'd0);
    check("s5.s1_data0", 64'(rob_s1_data), 64'd0);
    check("s5.s2_invalid", 64'(rob_s2_valid), 64'd0);
    check("s5.s2_data0", 64'(rob_s2_data), 64'd0);

    // ---- asynchronous reset mid-operation ----
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1; alloc_rd = 5'(i + 4); cyc();
    end
    alu_wb_valid = 1; alu_wb_rob_id = 3'd0; alu_wb_data = 32'h77; cyc();
    #1;
    check("s6.live_count", 64'(count), 64'd3);
    check("s6.live_commit", 64'(commit_valid), 64'd1);
    #1; rst = 1; #1;
    check_reset_outputs("s6");
    #1; rst = 0;
    cyc();
    alu_wb_valid = 1; alu_wb_rob_id = 3'd1; alu_wb_data = 32'hBEEF; cyc();
    rs1_rob_entry = 3'd1; #1;
    check("s6.late_wb_valid", 64'(rob_s1_valid), 64'd0);
    check("s6.late_wb_data", 64'(rob_s1_data), 64'd0);
    check("s6.late_count", 64'(count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
